// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: takes a word over valid/ready and shifts it
// out one bit per clock on a complementary pair, back-to-back frames with no gaps.
//
// state | meaning
// IDLE  | no frame on the line, sdo held low
// SHIFT | a frame is on the line, cnt counts remaining bits down to 0
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sdo,
  output logic             sdo_n,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               alive_q;
  logic               last;
  logic               accept;
  logic [WIDTH-1:0]   shifted;

  assign last       = (state_q == SHIFT) && (cnt_q == '0);
  assign load_ready = alive_q && ((state_q == IDLE) || last);
  assign accept     = load_valid && load_ready;

  // Shift moves the next bit toward whichever end drives sdo.
  assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                             : {1'b0, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      // A load in the last cycle wins over the return to IDLE.
      state_d = SHIFT;
      shreg_d = load_data;
      cnt_d   = CNT_W'(WIDTH - 1);
    end else if (state_q == SHIFT) begin
      if (cnt_q != '0) begin
        shreg_d = shifted;
        cnt_d   = cnt_q - 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      alive_q <= 1'b1;
    end
  end

  assign sdo   = (state_q == SHIFT) && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign sdo_n = ~sdo;
  assign busy  = (state_q == SHIFT);
  assign done  = last;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: an MSB-first and an LSB-first instance share stimulus,
// and per-cycle expected line states are queued at load time and popped each cycle.
module tb_piso_tx;

  localparam int W = 8;

  typedef struct packed {
    logic sdo;
    logic busy;
    logic done;
    logic ready;
  } rec_t;

  localparam rec_t IDLE_REC = '{sdo: 1'b0, busy: 1'b0, done: 1'b0, ready: 1'b1};

  logic         clk;
  logic         rst_n;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         ready_m, sdo_m, sdo_n_m, busy_m, done_m;
  logic         ready_l, sdo_l, sdo_n_l, busy_l, done_l;

  int vecs = 0;
  int errs = 0;

  rec_t qm[$];
  rec_t ql[$];

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (ready_m),
    .sdo        (sdo_m),
    .sdo_n      (sdo_n_m),
    .busy       (busy_m),
    .done       (done_m)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (ready_l),
    .sdo        (sdo_l),
    .sdo_n      (sdo_n_l),
    .busy       (busy_l),
    .done       (done_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " m_sdo"},   sdo_m,   1'b0);
    chk({tag, " m_sdo_n"}, sdo_n_m, 1'b1);
    chk({tag, " m_busy"},  busy_m,  1'b0);
    chk({tag, " m_done"},  done_m,  1'b0);
    chk({tag, " m_ready"}, ready_m, 1'b0);
    chk({tag, " l_sdo"},   sdo_l,   1'b0);
    chk({tag, " l_sdo_n"}, sdo_n_l, 1'b1);
    chk({tag, " l_busy"},  busy_l,  1'b0);
    chk({tag, " l_done"},  done_l,  1'b0);
    chk({tag, " l_ready"}, ready_l, 1'b0);
  endtask

  // Drive a word and queue the expected per-cycle line state for both bit orders.
  task automatic offer(input logic [W-1:0] w);
    rec_t r;
    load_valid = 1'b1;
    load_data  = w;
    for (int k = 0; k < W; k++) begin
      r.busy  = 1'b1;
      r.done  = (k == W - 1);
      r.ready = (k == W - 1);
      r.sdo   = w[W-1-k];
      qm.push_back(r);
      r.sdo   = w[k];
      ql.push_back(r);
    end
  endtask

  task automatic drop_valid();
    load_valid = 1'b0;
    load_data  = W'($urandom);
  endtask

  task automatic run(input int n, input string tag);
    rec_t em, el;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      em = (qm.size() != 0) ? qm.pop_front() : IDLE_REC;
      el = (ql.size() != 0) ? ql.pop_front() : IDLE_REC;
      chk($sformatf("%s m_sdo", tag),   sdo_m,   em.sdo);
      chk($sformatf("%s m_sdo_n", tag), sdo_n_m, ~em.sdo);
      chk($sformatf("%s m_busy", tag),  busy_m,  em.busy);
      chk($sformatf("%s m_done", tag),  done_m,  em.done);
      chk($sformatf("%s m_ready", tag), ready_m, em.ready);
      chk($sformatf("%s l_sdo", tag),   sdo_l,   el.sdo);
      chk($sformatf("%s l_sdo_n", tag), sdo_n_l, ~el.sdo);
      chk($sformatf("%s l_busy", tag),  busy_l,  el.busy);
      chk($sformatf("%s l_done", tag),  done_l,  el.done);
      chk($sformatf("%s l_ready", tag), ready_l, el.ready);
    end
  endtask

  task automatic send(input logic [W-1:0] w, input string tag);
    offer(w);
    run(1, tag);
    drop_valid();
    run(W, tag);
  endtask

  initial begin
    rst_n      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    #1 rst_n = 1'b0;

    // Reset held for three edges, then release.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_reset_outputs("rst");
    end
    rst_n = 1'b1;
    chk("rel m_ready_before_edge", ready_m, 1'b0);
    chk("rel l_ready_before_edge", ready_l, 1'b0);
    run(1, "rel");

    send(8'hA5, "a5");
    send(8'hC1, "c1");

    // Back-to-back: FF then 00 loaded during FF's last cycle.
    offer(8'hFF);
    run(1, "b2b");
    drop_valid();
    run(W - 1, "b2b");
    offer(8'h00);
    run(1, "b2b");
    drop_valid();
    run(W, "b2b");

    // Busy rejection during cycle 3 of a 3C frame.
    offer(8'h3C);
    run(1, "rej");
    drop_valid();
    run(1, "rej");
    run(1, "rej");
    load_valid = 1'b1;
    load_data  = 8'hFF;
    run(1, "rej");
    drop_valid();
    run(W - 3, "rej");

    // Reset mid-frame during cycle 4 of an F0 frame.
    offer(8'hF0);
    run(1, "mid");
    drop_valid();
    run(3, "mid");
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_async");
    qm.delete();
    ql.delete();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk_reset_outputs("mid_hold");
    end
    rst_n = 1'b1;
    chk("mid m_ready_before_edge", ready_m, 1'b0);
    chk("mid l_ready_before_edge", ready_l, 1'b0);
    run(1, "mid_rel");
    send(8'h81, "81");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out bit transmitter: it accepts a WIDTH-bit word through a valid/ready handshake and drives it out one bit per clock on a complementary pair, `sdo` and `sdo_n`. It is the driving end of the single-bit data line that our D flip-flop capture stages sample on the rising edge. It is the source for serial links inside the design, and it sends back-to-back frames with no gap cycles.

## Interface
Parameters:
- `WIDTH`, 8: word length in bits; legal range is 2 to 32.
- `MSB_FIRST`, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `load_valid`  in  1  the word on `load_data` is offered.
- `load_data`  in  WIDTH  word to transmit.
- `load_ready`  out  1  the transmitter can accept a word in this cycle.
- `sdo`  out  1  serial data bit.
- `sdo_n`  out  1  always equal to ~`sdo`.
- `busy`  out  1  a frame is on the line.
- `done`  out  1  one-cycle pulse that marks the last bit of a frame.

## Operation
- State machine with two states.
  - IDLE: no frame on the line.
  - SHIFT: a frame is on the line.
- Registers:
  - `shreg`, WIDTH bits: the word being sent.
  - `cnt`, $clog2(WIDTH) bits: down-counter for remaining bits.
  - `state`.
  - `alive`: 1-bit flop, cleared by reset, set on the first rising edge after reset release.
- `last` = (state==SHIFT) && (cnt==0).
- `load_ready` = `alive` && (state==IDLE || `last`). This is combinational from registers only; it never depends on `load_valid`.
- A word is accepted on a rising edge where `load_valid` && `load_ready`. On acceptance:
  - `shreg` <= `load_data`.
  - `cnt` <= WIDTH-1.
  - state <= SHIFT.
- In SHIFT without acceptance:
  - If `cnt` != 0: shift `shreg` toward the output end and decrement `cnt`.
  - If `cnt` == 0: go to IDLE.
- Output bit selection:
  - `sdo` = `shreg`[WIDTH-1] when MSB_FIRST=1, else `shreg`[0], while in SHIFT.
  - `sdo` = 0 in IDLE.
- `busy` = (state==SHIFT).
- `done` = `last`.
- `load_valid` is ignored when `load_ready` is 0. The word in flight is never modified.
- `load_data` is sampled only on the accepting edge. It may change freely at any other time.

## Timing
- Reset (`rst_n` low), applied asynchronously and held for as long as `rst_n` is low:
  - `sdo`=0, `sdo_n`=1, `busy`=0, `done`=0, `load_ready`=0.
  - State is IDLE and `cnt`=0.
- Reset release: `load_ready` rises after the first rising edge with `rst_n` high.
- Latency: the first bit appears on `sdo` in the cycle right after the accepting edge (cycle 1). Bit k appears in cycle k+1. The last bit appears in cycle WIDTH, and `done` is high in that cycle only.
- Frame length: exactly WIDTH cycles with `busy`=1.
- Back-to-back: a word accepted during the `last` cycle puts its first bit on `sdo` in the very next cycle. `busy` stays high and `sdo` has no idle cycle between frames.
- Accept and `last` in the same cycle: the load takes priority over the return to IDLE.
- Reset mid-frame: the frame is dropped immediately (no partial completion). The outputs take their reset values asynchronously, and no `done` pulse is produced.
- `sdo` and `sdo_n` are complementary in every cycle, including during reset.

## Test plan
- Reset values: hold `rst_n`=0 for 3 cycles. Require `sdo`=0, `sdo_n`=1, `busy`=0, `done`=0, `load_ready`=0. After release, require `load_ready`=1 after the first edge.
- MSB-first (WIDTH=8): load 8'hA5. Require `sdo` = 1,0,1,0,0,1,0,1 in cycles 1-8 with `sdo_n` inverted, `busy`=1 in cycles 1-8, `done` only in cycle 8, and `sdo`=0 with `busy`=0 in cycle 9.
- LSB-first (MSB_FIRST=0): load 8'hC1. Require `sdo` = 1,0,0,0,0,0,1,1 in cycles 1-8.
- Back-to-back: load 8'hFF, then keep `load_valid` high with 8'h00 at the cycle-8 edge. Require `sdo`=1 for cycles 1-8 and 0 for cycles 9-16, `busy` continuously high for 16 cycles, and `done` in cycles 8 and 16.
- Busy rejection: during cycle 3 of an 8'h3C frame, drive `load_valid`=1 with 8'hFF. Require `load_ready`=0 and an unaltered 0,0,1,1,1,1,0,0 sequence.
- Reset mid-frame: pull `rst_n` low during cycle 4 of an 8'hF0 frame. Require `sdo`=0, `sdo_n`=1 and `busy`=0 with no clock edge, and no `done`. After release, load 8'h81 and require 1,0,0,0,0,0,0,1.
